// File: rtl/evt_delay_line.sv
// Event-driven delay line: DEPTH-stage data/valid pipeline with a selectable output tap,
// event toggle flag and event counter. EVT_CNT_SAT_EN selects a saturating counter with sticky overflow.
module evt_delay_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     evt_in,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(DEPTH)-1:0] tap_sel,
    input  logic                     flush,
    output logic [WIDTH-1:0]         data_out,
    output logic                     valid_out,
    output logic                     toggle_out,
    output logic                     busy,
    output logic [CNT_W-1:0]         evt_count,
    output logic                     overflow
);

    // state | meaning
    // IDLE  | no stage holds a valid sample
    // RUN   | at least one stage holds a valid sample
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            stage_vld  <= '0;
            toggle_out <= 1'b0;
            evt_count  <= '0;
            overflow   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_data[k] <= '0;
            end
        end else begin
            // Stage 0 keeps its old data between events; the data path shifts every cycle.
            if (evt_in) begin
                stage_data[0] <= data_in;
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage_data[k] <= stage_data[k-1];
            end

            if (flush) begin
                stage_vld <= '0;
            end else begin
                stage_vld <= {stage_vld[DEPTH-2:0], evt_in};
            end

            // busy tracks whether any valid survives this edge
            case (state)
                IDLE: begin
                    if (evt_in && !flush) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (flush || (!evt_in && stage_vld[DEPTH-2:0] == '0)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (evt_in) begin
                toggle_out <= ~toggle_out;
            end

`ifdef EVT_CNT_SAT_EN
            if (evt_in) begin
                if (evt_count == CNT_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    evt_count <= evt_count + 1'b1;
                end
            end
`else
            overflow <= evt_in && (evt_count == CNT_MAX);
            if (evt_in) begin
                evt_count <= evt_count + 1'b1;
            end
`endif
        end
    end

    assign busy = (state == RUN);

    always_comb begin
        data_out  = '0;
        valid_out = 1'b0;
        if (int'(tap_sel) < DEPTH) begin
            data_out  = stage_data[tap_sel];
            valid_out = stage_vld[tap_sel];
        end
    end

endmodule

// File: tb/tb_evt_delay_line.sv
// Self-checking bench for evt_delay_line: directed scenarios plus random traffic against
// an event-history reference model. Honours EVT_CNT_SAT_EN for the counter expectations.
module tb_evt_delay_line;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;
    localparam int MAXC  = 2048;

    logic             clk = 1'b0;
    logic             rst, evt_in, flush;
    logic [WIDTH-1:0] data_in;
    logic [2:0]       tap_sel;
    logic [WIDTH-1:0] data_out;
    logic             valid_out, toggle_out, busy, overflow;
    logic [CNT_W-1:0] evt_count;

    evt_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .evt_in(evt_in), .data_in(data_in), .tap_sel(tap_sel),
        .flush(flush), .data_out(data_out), .valid_out(valid_out), .toggle_out(toggle_out),
        .busy(busy), .evt_count(evt_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // History of what each edge sampled: accepted event, its data, reset, and any valid-clearing event.
    bit             ev_h [MAXC];
    bit             rs_h [MAXC];
    bit             cl_h [MAXC];
    logic [WIDTH-1:0] d_h [MAXC];
    int             n_evt   = 0;
    bit             ev_last = 0;

    function automatic bit m_valid(input int k);
        int idx = cyc - k;
        if (idx < 1) return 1'b0;
        if (!ev_h[idx]) return 1'b0;
        for (int j = idx; j <= cyc; j++) if (cl_h[j]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] m_data(input int k);
        int idx = cyc - k;
        for (int j = idx + 1; j <= cyc; j++) if (j >= 1 && rs_h[j]) return '0;
        for (int j = idx; j >= 1; j--) begin
            if (rs_h[j]) return '0;
            if (ev_h[j]) return d_h[j];
        end
        return '0;
    endfunction

    function automatic int m_count();
`ifdef EVT_CNT_SAT_EN
        return (n_evt > 15) ? 15 : n_evt;
`else
        return n_evt % 16;
`endif
    endfunction

    function automatic bit m_ovf();
`ifdef EVT_CNT_SAT_EN
        return n_evt >= 16;
`else
        return ev_last && n_evt > 0 && (n_evt % 16) == 0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit any = 0;
        for (int k = 0; k < DEPTH; k++) any |= m_valid(k);
        chk("valid_out",  32'(valid_out),  32'(m_valid(int'(tap_sel))));
        chk("data_out",   32'(data_out),   32'(m_data(int'(tap_sel))));
        chk("busy",       32'(busy),       32'(any));
        chk("toggle_out", 32'(toggle_out), 32'(n_evt % 2));
        chk("evt_count",  32'(evt_count),  32'(m_count()));
        chk("overflow",   32'(overflow),   32'(m_ovf()));
    endtask

    task automatic tick(input bit e, input logic [WIDTH-1:0] d, input bit f, input bit r,
                        input logic [2:0] ts);
        evt_in  = e;
        data_in = d;
        flush   = f;
        rst     = r;
        tap_sel = ts;
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget observed=%0d expected<%0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        ev_h[cyc] = e && !r;
        d_h[cyc]  = d;
        rs_h[cyc] = r;
        cl_h[cyc] = f || r;
        if (r) begin
            n_evt   = 0;
            ev_last = 0;
        end else begin
            ev_last = e;
            if (e) n_evt++;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        rst = 1'b1; evt_in = 1'b0; flush = 1'b0; data_in = '0; tap_sel = '0;

        // Reset, then idle
        tick(0, 16'h0, 0, 1, 0);
        tick(0, 16'h0, 0, 1, 0);
        chk("rst_outputs", {data_out, 7'(valid_out), toggle_out, busy, overflow, 4'(evt_count)}, 32'h0);
        for (int i = 0; i < 20; i++) tick(0, 16'h0, 0, 0, 3'($urandom_range(0, 7)));
        chk("idle_busy", 32'(busy), 32'h0);

        // Single event at tap 3
        tick(1, 16'hA5A5, 0, 0, 3);
        chk("single_toggle", 32'(toggle_out), 32'h1);
        chk("single_count",  32'(evt_count),  32'h1);
        for (int i = 1; i <= 9; i++) begin
            tick(0, 16'h0, 0, 0, 3);
            if (i == 3) chk("single_hit", {15'h0, valid_out, data_out}, {15'h0, 1'b1, 16'hA5A5});
            else        chk("single_quiet", 32'(valid_out), 32'h0);
            if (i == 7) chk("single_busy_last", 32'(busy), 32'h1);
            if (i == 8) chk("single_busy_fall", 32'(busy), 32'h0);
        end

        // Burst of 8 at tap 7
        tick(0, 16'h0, 0, 1, 7);
        for (int i = 1; i <= 8; i++) tick(1, 16'(i), 0, 0, 7);
        chk("burst_toggle", 32'(toggle_out), 32'h0);
        chk("burst_count",  32'(evt_count),  32'h8);
        chk("burst_first",  32'(data_out),   32'h1);
        for (int i = 2; i <= 8; i++) begin
            tick(0, 16'h0, 0, 0, 7);
            chk("burst_seq", {15'h0, valid_out, data_out}, {15'h0, 1'b1, 16'(i)});
        end
        tick(0, 16'h0, 0, 0, 7);

        // Flush with a simultaneous event
        tick(0, 16'h0, 0, 1, 0);
        for (int i = 1; i <= 3; i++) tick(1, 16'(16'h100 + i), 0, 0, 0);
        tick(1, 16'h1234, 1, 0, 0);
        chk("flush_busy",   32'(busy),       32'h0);
        chk("flush_count",  32'(evt_count),  32'h4);
        chk("flush_toggle", 32'(toggle_out), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 16'h0, 0, 0, 3'(i));
            chk("flush_novalid", 32'(valid_out), 32'h0);
        end

        // Counter overflow with 17 events
        tick(0, 16'h0, 0, 1, 0);
        for (int i = 1; i <= 16; i++) tick(1, 16'(i), 0, 0, 0);
`ifdef EVT_CNT_SAT_EN
        chk("ovf16_count", 32'(evt_count), 32'hF);
        chk("ovf16_flag",  32'(overflow),  32'h1);
        tick(1, 16'h11, 0, 0, 0);
        chk("ovf17_count", 32'(evt_count), 32'hF);
        tick(0, 16'h0, 0, 0, 0);
        chk("ovf_sticky",  32'(overflow),  32'h1);
`else
        chk("ovf16_count", 32'(evt_count), 32'h0);
        chk("ovf16_flag",  32'(overflow),  32'h1);
        tick(1, 16'h11, 0, 0, 0);
        chk("ovf17_count", 32'(evt_count), 32'h1);
        chk("ovf17_flag",  32'(overflow),  32'h0);
`endif

        // Reset in the middle of a burst, then resume
        tick(0, 16'h0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) tick(1, 16'(16'hBEE0 + i), 0, 0, 2);
        tick(1, 16'hDEAD, 1, 1, 2);
        chk("midrst_outputs", {data_out, 7'(valid_out), toggle_out, busy, overflow, 4'(evt_count)}, 32'h0);
        tick(1, 16'h5A5A, 0, 0, 0);
        chk("resume_hit", {15'h0, valid_out, data_out}, {15'h0, 1'b1, 16'h5A5A});
        for (int i = 0; i < 8; i++) tick(0, 16'h0, 0, 0, 3'(i + 1));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom_range(0, 1)), 16'($urandom()), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) == 0), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
